fp_special_case_stage: RTL and testbench
========================================

# fp_special_case_stage

Two-stage pipelined front end for the FPU add/sub/mul datapath. It classifies both operands, resolves every IEEE-754 special-case result (NaN, infinity, zero) and flags invalid operations. It hands operands on to the normal arithmetic path with a bypass indication. It sits directly downstream of the operand classifier (one classifier instance per operand) and upstream of the adder/multiplier cores, using valid/ready handshakes on both sides.

## Interface
Parameters:
- EXPONENT_WIDTH, 8, exponent field width.
- MANTISSA_WIDTH, 23, stored mantissa width; word width W = EXPONENT_WIDTH+MANTISSA_WIDTH+1.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  stage can accept a bundle this cycle.
- in_op  input  2  00 add, 01 sub, 10 mul, 11 reserved (treated as add).
- in_a, in_b  input  W  operands, {sign, exponent, mantissa}.
- out_valid  output  1  result bundle valid.
- out_ready  input  1  consumer accepts the bundle this cycle.
- out_bypass  output  1  1 means out_result is final; 0 means the normal datapath must compute.
- out_result  output  W  special-case result; all zeros when out_bypass=0.
- out_nv  output  1  IEEE invalid-operation flag for this bundle.
- out_op  output  2  registered in_op (11 forwarded as 00).
- out_a, out_b  output  W  registered operands, unmodified.

## Operation
- Stage 1 registers the operands, the op, and both classifications: zero, infinite, subnormal, NaN, and sNaN.
  - NaN: exponent all ones and mantissa nonzero. The sign bit is ignored.
  - sNaN: a NaN whose mantissa MSB is 0.
- Stage 2 computes bypass, result and nv from the stage-1 registers.
- Canonical NaN: sign 0, exponent all ones, mantissa MSB 1 and all other mantissa bits 0 (FP32 0x7FC00000).
- Effective b sign for add/sub: sb' = b.sign ^ (op==sub). For mul, s = a.sign ^ b.sign.
- Priority, first match wins:
  1. Either operand NaN: result is the canonical NaN, bypass=1. nv=1 if either operand is an sNaN.
  2. add/sub, both infinite, a.sign != sb': result is the canonical NaN, nv=1.
  3. add/sub, either operand infinite: result is that infinity, using sb' when it is b.
  4. add/sub, both zero: result is zero with sign a.sign & sb' (round-to-nearest).
  5. add/sub, exactly one zero: result is the other operand (b with its sign replaced by sb').
  6. mul, infinity times zero (either order): result is the canonical NaN, nv=1.
  7. mul, either operand infinite: result is infinity with sign s.
  8. mul, either operand zero: result is zero with sign s.
  9. Otherwise bypass=0, result=0, nv=0. Subnormals fall through to this case.
- Rules 1–8 set bypass=1.
- nv=0 in every case that does not state nv=1.

## Timing
- Reset, asynchronous: both stage-valid bits clear. out_valid=0, out_bypass=0, out_nv=0; out_result, out_a, out_b = 0; out_op=00; in_ready=1 once the pipeline is empty.
- Reset mid-operation discards all in-flight bundles; none reappear after reset.
- Stage 2 loads when !s2_valid || out_ready.
- Stage 1 loads when !s1_valid || stage 2 loads.
- in_ready = (!s1_valid || stage 2 loads). This is combinational from out_ready; there is no path from in_valid to in_ready.
- A transfer occurs on in_valid && in_ready, and on out_valid && out_ready.
- Latency: a bundle accepted at edge N shows out_valid=1 after edge N+1 (one stage-1 register, one stage-2 register, results registered at stage 2).
- Throughput: one bundle per cycle with out_ready held high.
- While out_valid && !out_ready, all out_* signals stay stable.
- Ordering is strictly FIFO, with at most 2 bundles in flight.
- Full pipeline with out_ready low: in_ready=0.
- Simultaneous output drain and input accept in the same cycle is allowed with no bubble.

## Test plan
- add 0x7F800000 + 0xFF800000 -> out_result 0x7FC00000, bypass=1, nv=1. sub of the same pair -> 0x7F800000, nv=0.
- mul 0x7F800000 × 0x00000000, and the reversed order -> 0x7FC00000, nv=1. mul 0xFF800000 × 0x3F800000 -> 0xFF800000, nv=0.
- add 0x7F800001 + 0x3F800000 (sNaN) -> 0x7FC00000, nv=1. add 0xFFC00001 + 0x3F800000 (qNaN) -> 0x7FC00000, nv=0.
- add 0x80000000 + 0x80000000 -> 0x80000000. sub 0x80000000 − 0x00000000 -> 0x80000000. sub 0x00000000 − 0x3F800000 -> 0xBF800000, bypass=1.
- add 0x3F800000 + 0x40000000 -> bypass=0, result 0, out_a/out_b/out_op equal the inputs. Subnormal 0x00000001 × 0x3F800000 -> bypass=0.
- Backpressure and reset:
  - 4 back-to-back bundles with out_ready=0 for 5 cycles -> in_ready falls after 2 accepts, outputs stay stable, all 4 drain in order.
  - rst asserted with 2 bundles in flight -> out_valid=0 immediately, and no stale bundle appears after release.

Source files
------------

// File: rtl/fp_special_case_stage.sv
// FPU add/sub/mul front end: classifies operands, resolves IEEE-754
// special-case results, and forwards operands to the arithmetic cores.
module fp_special_case_stage #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [1:0] in_op,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] in_a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] in_b,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bypass,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out_result,
  output logic out_nv,
  output logic [1:0] out_op,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out_a,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out_b
);

  localparam int E = EXPONENT_WIDTH;
  localparam int M = MANTISSA_WIDTH;
  localparam int W = E + M + 1;
  localparam logic [W-1:0] CANON =
    {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

  typedef enum logic [2:0] {
    CLS_NORM, CLS_ZERO, CLS_SUB, CLS_INF, CLS_QNAN, CLS_SNAN
  } fp_cls_e;

  typedef struct packed {
    logic [1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    fp_cls_e ca;
    fp_cls_e cb;
  } s1_t;

  function automatic fp_cls_e classify(input logic [W-1:0] x);
    logic [E-1:0] e;
    logic [M-1:0] m;
    fp_cls_e c;
    e = x[W-2:M];
    m = x[M-1:0];
    c = CLS_NORM;
    unique case (1'b1)
      (e == '0) && (m == '0): c = CLS_ZERO;
      (e == '0) && (m != '0): c = CLS_SUB;
      (&e) && (m == '0): c = CLS_INF;
      (&e) && m[M-1]: c = CLS_QNAN;
      (&e) && (m != '0) && !m[M-1]: c = CLS_SNAN;
      default: c = CLS_NORM;
    endcase
    return c;
  endfunction

  logic s1_valid, s2_valid;
  logic s1_load, s2_load;
  s1_t s1_d, s1_q;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign out_valid = s2_valid;

  always_comb begin
    s1_d.op = (in_op == 2'b11) ? 2'b00 : in_op;
    s1_d.a  = in_a;
    s1_d.b  = in_b;
    s1_d.ca = classify(in_a);
    s1_d.cb = classify(in_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  logic a_nan, b_nan, a_snan, b_snan;
  logic a_inf, b_inf, a_zero, b_zero;
  logic is_mul, is_sub, a_sign, sb, s_mul;
  logic [W-1:0] b_eff;
  logic byp, nv;
  logic [W-1:0] res;

  always_comb begin
    a_snan = s1_q.ca == CLS_SNAN;
    b_snan = s1_q.cb == CLS_SNAN;
    a_nan  = a_snan || (s1_q.ca == CLS_QNAN);
    b_nan  = b_snan || (s1_q.cb == CLS_QNAN);
    a_inf  = s1_q.ca == CLS_INF;
    b_inf  = s1_q.cb == CLS_INF;
    a_zero = s1_q.ca == CLS_ZERO;
    b_zero = s1_q.cb == CLS_ZERO;
    is_mul = s1_q.op == 2'b10;
    is_sub = s1_q.op == 2'b01;
    a_sign = s1_q.a[W-1];
    sb     = s1_q.b[W-1] ^ is_sub;
    s_mul  = s1_q.a[W-1] ^ s1_q.b[W-1];
    b_eff  = {sb, s1_q.b[W-2:0]};
  end

  always_comb begin
    byp = 1'b1;
    res = '0;
    nv  = 1'b0;
    if (a_nan || b_nan) begin
      res = CANON;
      nv  = a_snan || b_snan;
    end else if (!is_mul) begin
      if (a_inf && b_inf && (a_sign != sb)) begin
        res = CANON;
        nv  = 1'b1;
      end else if (a_inf) res = s1_q.a;
      else if (b_inf) res = b_eff;
      // both-zero sign follows round-to-nearest
      else if (a_zero && b_zero)
        res = {a_sign & sb, {(W-1){1'b0}}};
      else if (a_zero) res = b_eff;
      else if (b_zero) res = s1_q.a;
      else byp = 1'b0;
    end else begin
      if ((a_inf && b_zero) || (a_zero && b_inf)) begin
        res = CANON;
        nv  = 1'b1;
      end else if (a_inf || b_inf)
        res = {s_mul, {E{1'b1}}, {M{1'b0}}};
      else if (a_zero || b_zero)
        res = {s_mul, {(W-1){1'b0}}};
      else byp = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      out_bypass <= 1'b0;
      out_result <= '0;
      out_nv     <= 1'b0;
      out_op     <= 2'b00;
      out_a      <= '0;
      out_b      <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_bypass <= byp;
        out_result <= res;
        out_nv     <= nv;
        out_op     <= s1_q.op;
        out_a      <= s1_q.a;
        out_b      <= s1_q.b;
      end
    end
  end

endmodule

// File: tb/tb_fp_special_case_stage.sv
// Directed bench for fp_special_case_stage: special-case vector
// table plus backpressure and mid-flight reset sequences.
module tb_fp_special_case_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] in_op = 2'b00;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic out_bypass;
  logic [31:0] out_result;
  logic out_nv;
  logic [1:0] out_op;
  logic [31:0] out_a;
  logic [31:0] out_b;

  int checks = 0;
  int errors = 0;

  fp_special_case_stage #(
    .EXPONENT_WIDTH(8),
    .MANTISSA_WIDTH(23)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op(in_op),
    .in_a(in_a),
    .in_b(in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bypass(out_bypass),
    .out_result(out_result),
    .out_nv(out_nv),
    .out_op(out_op),
    .out_a(out_a),
    .out_b(out_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic byp;
    logic [31:0] res;
    logic nv;
    logic [1:0] eop;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{2'd0, 32'h7F800000, 32'hFF800000, 1'b1, 32'h7FC00000, 1'b1, 2'd0};
    vecs[1]  = '{2'd1, 32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 1'b0, 2'd1};
    vecs[2]  = '{2'd2, 32'h7F800000, 32'h00000000, 1'b1, 32'h7FC00000, 1'b1, 2'd2};
    vecs[3]  = '{2'd2, 32'h00000000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b1, 2'd2};
    vecs[4]  = '{2'd2, 32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 1'b0, 2'd2};
    vecs[5]  = '{2'd0, 32'h7F800001, 32'h3F800000, 1'b1, 32'h7FC00000, 1'b1, 2'd0};
    vecs[6]  = '{2'd0, 32'hFFC00001, 32'h3F800000, 1'b1, 32'h7FC00000, 1'b0, 2'd0};
    vecs[7]  = '{2'd0, 32'h80000000, 32'h80000000, 1'b1, 32'h80000000, 1'b0, 2'd0};
    vecs[8]  = '{2'd1, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 2'd1};
    vecs[9]  = '{2'd1, 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 1'b0, 2'd1};
    vecs[10] = '{2'd0, 32'h3F800000, 32'h40000000, 1'b0, 32'h00000000, 1'b0, 2'd0};
    vecs[11] = '{2'd2, 32'h00000001, 32'h3F800000, 1'b0, 32'h00000000, 1'b0, 2'd2};
    vecs[12] = '{2'd3, 32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 1'b0, 2'd0};
    vecs[13] = '{2'd0, 32'h00000000, 32'h40000000, 1'b1, 32'h40000000, 1'b0, 2'd0};
    vecs[14] = '{2'd2, 32'h80000000, 32'h3F800000, 1'b1, 32'h80000000, 1'b0, 2'd2};
    vecs[15] = '{2'd0, 32'h3F800000, 32'hFF800000, 1'b1, 32'hFF800000, 1'b0, 2'd0};
    vecs[16] = '{2'd2, 32'h7FC00000, 32'h00000000, 1'b1, 32'h7FC00000, 1'b0, 2'd2};
    vecs[17] = '{2'd0, 32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0, 2'd0};
    vecs[18] = '{2'd1, 32'hFF800000, 32'hFF800000, 1'b1, 32'h7FC00000, 1'b1, 2'd1};
    vecs[19] = '{2'd2, 32'h3F800000, 32'hFF800001, 1'b1, 32'h7FC00000, 1'b1, 2'd2};

    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_bypass", {31'b0, out_bypass}, 32'd0);
    chk("rst_out_nv", {31'b0, out_nv}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_out_op", {30'b0, out_op}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table vectors, one bundle at a time with out_ready high
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_op = vecs[i].op;
      in_a = vecs[i].a;
      in_b = vecs[i].b;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int t = 0; t < 4 && !out_valid; t++) @(negedge clk);
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("v%0d_bypass", i), {31'b0, out_bypass},
          {31'b0, vecs[i].byp});
      chk($sformatf("v%0d_result", i), out_result, vecs[i].res);
      chk($sformatf("v%0d_nv", i), {31'b0, out_nv}, {31'b0, vecs[i].nv});
      chk($sformatf("v%0d_op", i), {30'b0, out_op}, {30'b0, vecs[i].eop});
      chk($sformatf("v%0d_a", i), out_a, vecs[i].a);
      chk($sformatf("v%0d_b", i), out_b, vecs[i].b);
    end
    @(negedge clk);
    chk("idle_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: 4 back-to-back bundles, out_ready low for 5 cycles
    begin
      int sent, rcv;
      logic held;
      logic [31:0] held_a, held_res;
      logic accept;
      logic full_seen;
      sent = 0;
      rcv = 0;
      held = 1'b0;
      held_a = '0;
      held_res = '0;
      full_seen = 1'b0;
      for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
        @(negedge clk);
        out_ready = (cyc >= 5);
        in_valid = (sent < 4);
        in_op = 2'b00;
        in_a = 32'h3F800000 + sent;
        in_b = 32'h40000000;
        #1;
        if (held) begin
          chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
          chk("bp_hold_a", out_a, held_a);
          chk("bp_hold_res", out_result, held_res);
        end
        if (sent == 2 && !out_ready && !full_seen) begin
          full_seen = 1'b1;
          chk("bp_full_in_ready", {31'b0, in_ready}, 32'd0);
        end
        if (out_valid && out_ready) begin
          chk($sformatf("bp_order%0d", rcv), out_a, 32'h3F800000 + rcv);
          chk($sformatf("bp_bypass%0d", rcv), {31'b0, out_bypass}, 32'd0);
          rcv++;
        end
        held = out_valid && !out_ready;
        held_a = out_a;
        held_res = out_result;
        accept = in_valid && in_ready;
        @(posedge clk);
        if (accept) sent++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_full_seen", {31'b0, full_seen}, 32'd1);
      chk("bp_drained", rcv, 32'd4);
    end

    // Reset with two bundles in flight
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_op = 2'b10;
      in_a = 32'h7F800000;
      in_b = 32'h00000000;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_valid%0d", c), {31'b0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
